// File: rtl/i2c_port_arb.sv
// i2c_port_arb: locks the I2C slave onto the first enabled pin pair that shows a START
module i2c_port_arb #(
  parameter int NPORT = 5,
  parameter int TOUT_W = 16,
  parameter int TOUT = 48000
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic [NPORT-1:0] i_scl,
  input  logic [NPORT-1:0] i_sda,
  input  logic [NPORT-1:0] r_en,
  input  logic             i_sda_oe,
  output logic             o_scl,
  output logic             o_sda,
  output logic [NPORT-1:0] o_sda_oe,
  output logic [2:0]       o_sel,
  output logic             o_busy,
  output logic             o_tout
);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, RELEASE = 2'd2;
  logic [NPORT-1:0] scl_m, scl_s, scl_d, sda_m, sda_s, sda_d, start, stop;
  logic [1:0] st, st_n;
  logic [2:0] sel_n;
  logic rc, rc_n, abt, abt_n, tout_n, fol;
  logic [TOUT_W-1:0] cnt, cnt_n;
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop = scl_s & scl_d & ~sda_d & sda_s;
  assign fol = (st_n == ACTIVE) | ((st_n == RELEASE) & ~abt_n);
  // two-flop synchronizer plus one delay stage per pair; the output flops form the second delay
  always_ff @(posedge clk or negedge rstz)
    if (!rstz) begin
      scl_m <= '1;
      scl_s <= '1;
      scl_d <= '1;
      sda_m <= '1;
      sda_s <= '1;
      sda_d <= '1;
    end else begin
      scl_m <= i_scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= i_sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  // next-state: lowest-index START wins; disable beats timeout beats STOP
  always_comb begin
    st_n = st;
    sel_n = o_sel;
    rc_n = 1'b0;
    abt_n = abt;
    tout_n = 1'b0;
    if (st == IDLE) begin
      for (int k = NPORT - 1; k >= 0; k--)
        if (start[k] & r_en[k]) begin
          st_n = ACTIVE;
          sel_n = 3'(k);
        end
    end else if (st == ACTIVE) begin
      if (!r_en[o_sel]) begin
        st_n = RELEASE;
        abt_n = 1'b1;
      end else if (cnt == TOUT_W'(TOUT)) begin
        st_n = RELEASE;
        abt_n = 1'b1;
        tout_n = 1'b1;
      end else if (stop[o_sel]) begin
        st_n = RELEASE;
        abt_n = 1'b0;
      end
    end else begin
      rc_n = 1'b1;
      st_n = rc ? IDLE : RELEASE;
    end
    cnt_n = (st != ACTIVE || st_n != ACTIVE || scl_s[o_sel] != scl_d[o_sel]) ? '0 :
            (cnt == TOUT_W'(TOUT)) ? cnt : cnt + 1'b1;
  end
  // state and registered outputs; an aborted release drives a synthetic STOP (sda 0 then 1)
  always_ff @(posedge clk or negedge rstz)
    if (!rstz) begin
      st <= IDLE;
      rc <= 1'b0;
      abt <= 1'b0;
      cnt <= '0;
      o_scl <= 1'b1;
      o_sda <= 1'b1;
      o_sda_oe <= '0;
      o_sel <= '0;
      o_busy <= 1'b0;
      o_tout <= 1'b0;
    end else begin
      st <= st_n;
      rc <= rc_n;
      abt <= abt_n;
      cnt <= cnt_n;
      o_scl <= fol ? scl_d[sel_n] : 1'b1;
      o_sda <= fol ? sda_d[sel_n] : ~((st_n == RELEASE) & ~rc_n);
      o_sda_oe <= (st_n == ACTIVE && i_sda_oe) ? NPORT'(1) << sel_n : '0;
      o_sel <= sel_n;
      o_busy <= st_n != IDLE;
      o_tout <= tout_n;
    end
endmodule

// File: tb/tb_i2c_port_arb.sv
// tb_i2c_port_arb: table of settled pin states plus hand sequences for latency, timeout, abort and reset
module tb_i2c_port_arb;
  typedef struct {
    logic [4:0] scl, sda, en;
    logic oe, e_scl, e_sda;
    logic [4:0] e_oe;
    logic [2:0] e_sel;
    logic e_busy;
  } vec_t;
  logic clk = 0, rstz = 0, i_sda_oe = 0;
  logic [4:0] i_scl = '1, i_sda = '1, r_en = '1;
  logic o_scl, o_sda, o_busy, o_tout;
  logic [4:0] o_sda_oe;
  logic [2:0] o_sel;
  int checks = 0, errors = 0;
  vec_t vt[19];
  vec_t sbq[$];
  vec_t e;
  int n;
  always #5 clk = ~clk;
  i2c_port_arb #(.NPORT(5), .TOUT_W(16), .TOUT(100)) dut (
    .clk(clk), .rstz(rstz), .i_scl(i_scl), .i_sda(i_sda), .r_en(r_en), .i_sda_oe(i_sda_oe),
    .o_scl(o_scl), .o_sda(o_sda), .o_sda_oe(o_sda_oe), .o_sel(o_sel), .o_busy(o_busy), .o_tout(o_tout)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [4:0] scl, sda, en, input logic oe, e_scl, e_sda,
                              input logic [4:0] e_oe, input logic [2:0] e_sel, input logic e_busy);
    vec_t v;
    v.scl = scl; v.sda = sda; v.en = en; v.oe = oe; v.e_scl = e_scl; v.e_sda = e_sda;
    v.e_oe = e_oe; v.e_sel = e_sel; v.e_busy = e_busy;
    return v;
  endfunction
  initial begin
    vt[0]  = mk(5'h1F, 5'h1F, 5'h1F, 0, 1, 1, 5'h00, 0, 0);
    vt[1]  = mk(5'h1F, 5'h1B, 5'h1F, 0, 1, 0, 5'h00, 2, 1);
    vt[2]  = mk(5'h1B, 5'h1B, 5'h1F, 0, 0, 0, 5'h00, 2, 1);
    vt[3]  = mk(5'h1B, 5'h1B, 5'h1F, 1, 0, 0, 5'h04, 2, 1);
    vt[4]  = mk(5'h1B, 5'h1F, 5'h1F, 0, 0, 1, 5'h00, 2, 1);
    vt[5]  = mk(5'h1F, 5'h1F, 5'h1F, 0, 1, 1, 5'h00, 2, 1);
    vt[6]  = mk(5'h1F, 5'h1B, 5'h1F, 0, 1, 0, 5'h00, 2, 1);
    vt[7]  = mk(5'h1F, 5'h1F, 5'h1F, 0, 1, 1, 5'h00, 2, 0);
    vt[8]  = mk(5'h1F, 5'h15, 5'h1F, 0, 1, 0, 5'h00, 1, 1);
    vt[9]  = mk(5'h17, 5'h15, 5'h1F, 0, 1, 0, 5'h00, 1, 1);
    vt[10] = mk(5'h1F, 5'h1D, 5'h1F, 1, 1, 0, 5'h02, 1, 1);
    vt[11] = mk(5'h1D, 5'h1D, 5'h1F, 0, 0, 0, 5'h00, 1, 1);
    vt[12] = mk(5'h1D, 5'h1F, 5'h1F, 0, 0, 1, 5'h00, 1, 1);
    vt[13] = mk(5'h1F, 5'h1F, 5'h1F, 0, 1, 1, 5'h00, 1, 1);
    vt[14] = mk(5'h1F, 5'h1D, 5'h1F, 0, 1, 0, 5'h00, 1, 1);
    vt[15] = mk(5'h1F, 5'h1F, 5'h1F, 0, 1, 1, 5'h00, 1, 0);
    vt[16] = mk(5'h1F, 5'h1F, 5'h1F, 1, 1, 1, 5'h00, 1, 0);
    vt[17] = mk(5'h1F, 5'h1D, 5'h1D, 0, 1, 1, 5'h00, 1, 0);
    vt[18] = mk(5'h1F, 5'h1F, 5'h1D, 0, 1, 1, 5'h00, 1, 0);
    step(3);
    chk("rst_scl", o_scl, 1); chk("rst_sda", o_sda, 1); chk("rst_busy", o_busy, 0);
    rstz = 1;
    step(2);
    foreach (vt[i]) begin
      i_scl = vt[i].scl; i_sda = vt[i].sda; r_en = vt[i].en; i_sda_oe = vt[i].oe;
      sbq.push_back(vt[i]);
      step(8);
      e = sbq.pop_front();
      chk($sformatf("v%0d_scl", i), o_scl, e.e_scl);
      chk($sformatf("v%0d_sda", i), o_sda, e.e_sda);
      chk($sformatf("v%0d_oe", i), o_sda_oe, e.e_oe);
      chk($sformatf("v%0d_sel", i), o_sel, e.e_sel);
      chk($sformatf("v%0d_busy", i), o_busy, e.e_busy);
      chk($sformatf("v%0d_tout", i), o_tout, 0);
    end
    r_en = 5'h1F; i_scl = 5'h1F; i_sda = 5'h1F; i_sda_oe = 0;
    step(8);
    i_sda = 5'h1B;
    for (n = 0; n < 12 && o_sda !== 1'b0; n++) step(1);
    chk("start_lat", n, 4);
    chk("start_sel", o_sel, 2);
    step(4);
    i_sda = 5'h1F;
    for (n = 0; n < 12 && o_busy !== 1'b0; n++) step(1);
    chk("stop_release", n, 5);
    step(4);
    i_sda = 5'h1E;
    for (n = 0; n < 12 && o_busy !== 1'b1; n++) step(1);
    chk("to_lock", o_busy, 1);
    for (n = 0; n < 200 && o_tout !== 1'b1; n++) step(1);
    chk("to_lat_ok", (n >= 100 && n <= 101) ? 1 : 0, 1);
    chk("to_c1_scl", o_scl, 1); chk("to_c1_sda", o_sda, 0);
    step(1);
    chk("to_c2_tout", o_tout, 0); chk("to_c2_sda", o_sda, 1); chk("to_c2_busy", o_busy, 1);
    step(1);
    chk("to_idle", o_busy, 0);
    i_sda = 5'h1F;
    step(8);
    i_sda = 5'h1E;
    for (n = 0; n < 12 && o_busy !== 1'b1; n++) step(1);
    chk("ab_lock", o_sel, 0);
    i_scl = 5'h1E; i_sda_oe = 1;
    step(6);
    chk("ab_scl_low", o_scl, 0); chk("ab_oe0", o_sda_oe, 1);
    i_sda_oe = 0; r_en = 5'h1E;
    step(1);
    chk("ab_c1_scl", o_scl, 1); chk("ab_c1_sda", o_sda, 0); chk("ab_c1_busy", o_busy, 1);
    chk("ab_c1_tout", o_tout, 0);
    step(1);
    chk("ab_c2_scl", o_scl, 1); chk("ab_c2_sda", o_sda, 1); chk("ab_c2_busy", o_busy, 1);
    step(1);
    chk("ab_idle", o_busy, 0);
    i_scl = 5'h1F; i_sda = 5'h1F;
    step(8);
    r_en = 5'h1F;
    i_sda = 5'h17;
    for (n = 0; n < 12 && o_busy !== 1'b1; n++) step(1);
    i_sda_oe = 1;
    step(6);
    chk("rs_pre_sel", o_sel, 3); chk("rs_pre_oe", o_sda_oe, 8);
    #2 rstz = 0; i_sda = 5'h1F;
    #1;
    chk("rs_scl", o_scl, 1); chk("rs_sda", o_sda, 1); chk("rs_oe", o_sda_oe, 0);
    chk("rs_sel", o_sel, 0); chk("rs_busy", o_busy, 0); chk("rs_tout", o_tout, 0);
    i_sda_oe = 0;
    step(1);
    rstz = 1;
    step(3);
    i_sda = 5'h0F;
    for (n = 0; n < 12 && o_busy !== 1'b1; n++) step(1);
    chk("rs_new_busy", o_busy, 1); chk("rs_new_sel", o_sel, 4);
    i_sda = 5'h1F;
    for (n = 0; n < 12 && o_busy !== 1'b0; n++) step(1);
    chk("rs_new_done", o_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
